// File: rtl/traceback_unit_pkg.sv
// Shared constants and types for the traceback walker: direction-source
// encodings, alignment op codes, FSM and matrix states.
package traceback_unit_pkg;

    localparam int DIRECTION_WIDTH = 5;

    localparam logic [2:0] DIR_DIAG = 3'd0;
    localparam logic [2:0] DIR_E    = 3'd1;
    localparam logic [2:0] DIR_EH   = 3'd2;
    localparam logic [2:0] DIR_F    = 3'd3;
    localparam logic [2:0] DIR_FH   = 3'd4;
    localparam logic [2:0] DIR_STOP = 3'd5;

    localparam logic [1:0] OP_M = 2'd0;
    localparam logic [1:0] OP_D = 2'd1;
    localparam logic [1:0] OP_I = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DECODE,
        ST_EMIT,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        MAT_H,
        MAT_E,
        MAT_EH,
        MAT_F,
        MAT_FH
    } mat_e;

    // Matrix entered from H for a gap source; non-gap sources map to H.
    function automatic mat_e gap_matrix(input logic [2:0] src);
        case (src)
            DIR_E:   return MAT_E;
            DIR_EH:  return MAT_EH;
            DIR_F:   return MAT_F;
            DIR_FH:  return MAT_FH;
            default: return MAT_H;
        endcase
    endfunction

endpackage

// File: rtl/traceback_unit_if.sv
// Valid/ready stream carrying one alignment operation per transfer.
interface traceback_unit_if;
    logic       op_valid;
    logic [1:0] op_code;
    logic       op_ready;

    modport master (output op_valid, output op_code, input op_ready);
    modport slave  (input op_valid, input op_code, output op_ready);
endinterface

// File: rtl/traceback_unit_dir_lane_select.sv
// Picks one 5-bit direction code out of a packed column word; lane 0 sits
// in the most significant field, the last lane in the least significant.
module dir_lane_select
    import traceback_unit_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic [LANES*DIRECTION_WIDTH-1:0] i_word,
    input  logic [$clog2(LANES)-1:0]         i_lane,
    output logic [DIRECTION_WIDTH-1:0]       o_code
);
    localparam int LW = $clog2(LANES);

    always_comb begin
        o_code = '0;
        for (int l = 0; l < LANES; l++) begin
            if (i_lane == LW'(l)) begin
                o_code = i_word[(LANES-1-l)*DIRECTION_WIDTH +: DIRECTION_WIDTH];
            end
        end
    end
endmodule

// File: rtl/traceback_unit.sv
// Walks stored direction codes from the best cell back to the local-alignment
// start, issuing one SRAM read per step and emitting M/D/I ops downstream.
module traceback_unit
    import traceback_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 8,
    parameter int MEM_BLOCK_WIDTH = 4,
    parameter int LANES           = 16,
    parameter int RD_LAT          = 2
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic                               start,
    input  logic [ADDRESS_WIDTH-1:0]           tb_x,
    input  logic [ADDRESS_WIDTH-1:0]           tb_y,
    input  logic                               bank_sel,
    input  logic [LANES*DIRECTION_WIDTH-1:0]   column_k0,
    output logic                               use_s1,
    output logic [ADDRESS_WIDTH-1:0]           column_num,
    output logic [MEM_BLOCK_WIDTH-1:0]         mem_block_num,
    traceback_unit_if.master                   op_if,
    output logic                               busy,
    output logic                               done,
    output logic [ADDRESS_WIDTH-1:0]           start_x,
    output logic [ADDRESS_WIDTH-1:0]           start_y
);
    localparam int LANE_W = $clog2(LANES);
    localparam int CNT_W  = $clog2(RD_LAT + 1);

    state_e                       r_state, w_next;
    mat_e                         r_mat, w_mat_nxt;
    logic [ADDRESS_WIDTH-1:0]     r_x, r_y, r_sx, r_sy;
    logic [DIRECTION_WIDTH-1:0]   r_code;
    logic [CNT_W-1:0]             r_wcnt;
    logic                         r_use_s1;

    logic [DIRECTION_WIDTH-1:0]   w_code;
    logic [ADDRESS_WIDTH-1:0]     w_nx, w_ny;
    logic                         w_emit, w_gap, w_stop, w_step_x, w_step_y, w_term, w_hs;
    logic [1:0]                   w_op;

    dir_lane_select #(.LANES(LANES)) u_sel (
        .i_word (column_k0),
        .i_lane (r_y[LANE_W-1:0]),
        .o_code (w_code)
    );

    // Decode of the registered code in the current matrix.
    always_comb begin
        w_emit    = 1'b0;
        w_gap     = 1'b0;
        w_stop    = 1'b0;
        w_step_x  = 1'b0;
        w_step_y  = 1'b0;
        w_op      = OP_M;
        w_mat_nxt = r_mat;
        case (r_mat)
            MAT_H: begin
                if (r_code[2:0] == DIR_DIAG) begin
                    w_emit   = 1'b1;
                    w_step_x = 1'b1;
                    w_step_y = 1'b1;
                end else if (r_code[2:0] <= DIR_FH) begin
                    w_gap     = 1'b1;
                    w_mat_nxt = gap_matrix(r_code[2:0]);
                end else begin
                    w_stop = 1'b1;
                end
            end
            MAT_E, MAT_EH: begin
                w_emit    = 1'b1;
                w_op      = OP_D;
                w_step_x  = 1'b1;
                w_mat_nxt = ((r_mat == MAT_E) ? r_code[3] : r_code[4]) ? r_mat : MAT_H;
            end
            default: begin
                w_emit    = 1'b1;
                w_op      = OP_I;
                w_step_y  = 1'b1;
                w_mat_nxt = ((r_mat == MAT_F) ? r_code[3] : r_code[4]) ? r_mat : MAT_H;
            end
        endcase
    end

    // Saturating steps: a coordinate already at zero stays there.
    assign w_nx   = (w_step_x && r_x != '0) ? r_x - 1'b1 : r_x;
    assign w_ny   = (w_step_y && r_y != '0) ? r_y - 1'b1 : r_y;
    assign w_term = (w_nx == '0) || (w_ny == '0);

    assign op_if.op_valid = (r_state == ST_EMIT) && w_emit;
    assign op_if.op_code  = op_if.op_valid ? w_op : OP_M;
    assign w_hs           = op_if.op_valid && op_if.op_ready;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_ISSUE;
            ST_ISSUE:  w_next = (RD_LAT > 1) ? ST_WAIT : ST_DECODE;
            ST_WAIT:   if (r_wcnt == CNT_W'(RD_LAT - 2)) w_next = ST_DECODE;
            ST_DECODE: w_next = ST_EMIT;
            ST_EMIT: begin
                if (w_stop)     w_next = ST_DONE;
                else if (w_gap) w_next = ST_ISSUE;
                else if (w_hs)  w_next = w_term ? ST_DONE : ST_ISSUE;
            end
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_mat    <= MAT_H;
            r_x      <= '0;
            r_y      <= '0;
            r_sx     <= '0;
            r_sy     <= '0;
            r_code   <= '0;
            r_wcnt   <= '0;
            r_use_s1 <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_x      <= tb_x;
                    r_y      <= tb_y;
                    r_use_s1 <= bank_sel;
                    r_mat    <= MAT_H;
                end
                ST_ISSUE:  r_wcnt <= '0;
                ST_WAIT:   r_wcnt <= r_wcnt + 1'b1;
                ST_DECODE: r_code <= w_code;
                ST_EMIT: begin
                    if (w_gap) r_mat <= w_mat_nxt;
                    if (w_stop) begin
                        r_sx <= r_x;
                        r_sy <= r_y;
                    end
                    if (w_hs) begin
                        r_x   <= w_nx;
                        r_y   <= w_ny;
                        r_mat <= w_mat_nxt;
                        if (w_term) begin
                            r_sx <= w_nx;
                            r_sy <= w_ny;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign use_s1        = r_use_s1;
    assign column_num    = r_x;
    assign mem_block_num = r_y[LANE_W +: MEM_BLOCK_WIDTH];
    assign busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done          = (r_state == ST_DONE);
    assign start_x       = r_sx;
    assign start_y       = r_sy;
endmodule

// File: tb/tb_traceback_unit.sv
// Randomized and directed bench for traceback_unit against a direct walk
// over a behavioural direction matrix.
module tb_traceback_unit;
    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        reset_i, start, bank_sel;
    logic [7:0]  tb_x, tb_y;
    logic [79:0] column_k0 = '0;
    logic        use_s1, busy, done;
    logic [7:0]  column_num, start_x, start_y;
    logic [3:0]  mem_block_num;

    traceback_unit_if op_if ();

    traceback_unit #(.RD_LAT(RDL)) dut (
        .clk(clk), .reset_i(reset_i), .start(start), .tb_x(tb_x), .tb_y(tb_y),
        .bank_sel(bank_sel), .column_k0(column_k0), .use_s1(use_s1),
        .column_num(column_num), .mem_block_num(mem_block_num), .op_if(op_if),
        .busy(busy), .done(done), .start_x(start_x), .start_y(start_y)
    );

    always #5 clk = ~clk;

    bit [4:0] dirm [256][256];   // [row y][column x]
    int       checks = 0;
    int       errors = 0;
    int       exp_q[$];
    int       obs_q[$];
    int       exp_idx;
    int       ready_mode = 0;
    bit       tracking = 0;
    bit       r_trk = 0;
    bit       pend;
    int       pend_code;
    int       blk_seen;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [79:0] word_at(input logic [7:0] col, input logic [3:0] blk);
        logic [79:0] w;
        logic [3:0]  lb;
        w = '0;
        for (int l = 0; l < 16; l++) begin
            lb = 4'(l);
            w[(15-l)*5 +: 5] = dirm[int'({blk, lb})][int'(col)];
        end
        return w;
    endfunction

    // SRAM plus output register: RD_LAT-1 register stages after the address.
    always @(posedge clk) column_k0 <= word_at(column_num, mem_block_num);

    initial begin
        op_if.op_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       op_if.op_ready = 1'b1;
                1:       op_if.op_ready = ~op_if.op_ready;
                default: op_if.op_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle compare of the op stream against the model's op list.
    always @(negedge clk) begin
        if (tracking && !r_trk) begin
            exp_idx  = 0;
            obs_q.delete();
            pend     = 0;
            blk_seen = 0;
        end
        r_trk = tracking;
        if (tracking && reset_i) begin
            blk_seen = blk_seen | (1 << mem_block_num);
            if (pend) begin
                chk("hold_valid", op_if.op_valid, 1);
                chk("hold_code", op_if.op_code, pend_code);
            end
            pend      = op_if.op_valid && !op_if.op_ready;
            pend_code = int'(op_if.op_code);
            if (op_if.op_valid && op_if.op_ready) begin
                obs_q.push_back(int'(op_if.op_code));
                if (exp_idx < exp_q.size()) chk("op_code", op_if.op_code, exp_q[exp_idx]);
                else chk("op_extra", obs_q.size(), exp_q.size());
                exp_idx++;
            end
            if (done) chk("busy_at_done", busy, 0);
        end
    end

    function automatic int dec(input int v);
        return (v > 0) ? v - 1 : 0;
    endfunction

    // Walk the matrix directly: 0=H 1=E 2=Ehat 3=F 4=Fhat.
    task automatic model_walk(input int x0, input int y0, output int nreads, output int sx, output int sy);
        int x, y, m;
        bit [4:0] c;
        exp_q.delete();
        x = x0; y = y0; m = 0; nreads = 0;
        while (nreads < 4000) begin
            nreads++;
            c = dirm[y][x];
            if (m == 0) begin
                if (c[2:0] == 3'd0) begin
                    exp_q.push_back(0);
                    x = dec(x); y = dec(y);
                end else if (c[2:0] <= 3'd4) begin
                    m = int'(c[2:0]);
                    continue;
                end else break;
            end else begin
                exp_q.push_back((m <= 2) ? 1 : 2);
                if (m <= 2) x = dec(x); else y = dec(y);
                if (!(((m == 1) || (m == 3)) ? c[3] : c[4])) m = 0;
            end
            if (x == 0 || y == 0) break;
        end
        sx = x; sy = y;
    endtask

    task automatic fill(input bit [4:0] c);
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++) dirm[y][x] = c;
    endtask

    function automatic bit [4:0] rand_code();
        int r;
        bit [2:0] s;
        r = int'($urandom_range(0, 15));
        if (r < 6)       s = 3'd0;
        else if (r < 14) s = 3'(1 + (r - 6) / 2);
        else if (r == 14) s = 3'd5;
        else             s = 3'(6 + $urandom_range(0, 1));
        return {2'($urandom_range(0, 3)), s};
    endfunction

    task automatic run_walk(input string nm, input int x0, input int y0, input bit bank,
                            input int rmode, input bit lat_chk, input bit extra_start);
        int nreads, sx, sy, n;
        bit got;
        model_walk(x0, y0, nreads, sx, sy);
        ready_mode = rmode;
        @(posedge clk); #1;
        tb_x = 8'(x0); tb_y = 8'(y0); bank_sel = bank; start = 1'b1; tracking = 1;
        n = 0; got = 0;
        while (n < 20000) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (extra_start && n == 3) begin
                start = 1'b1; tb_x = 8'd1; tb_y = 8'd1; bank_sel = ~bank;
            end
            if (done) begin got = 1; break; end
        end
        chk({nm, "_done"}, got, 1);
        chk({nm, "_start_x"}, start_x, sx);
        chk({nm, "_start_y"}, start_y, sy);
        chk({nm, "_nops"}, exp_idx, exp_q.size());
        chk({nm, "_use_s1"}, use_s1, bank);
        chk({nm, "_column_num"}, column_num, sx);
        chk({nm, "_mem_block"}, mem_block_num, sy / 16);
        if (lat_chk) chk({nm, "_latency"}, n, 1 + nreads * (RDL + 2));
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, done, 0);
        tracking = 0;
    endtask

    int ref_q[$];
    int nd, ni, diffs, n;
    bit got;

    initial begin
        reset_i = 1'b0; start = 1'b0; bank_sel = 1'b0; tb_x = '0; tb_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
        chk("rst_valid", op_if.op_valid, 0); chk("rst_code", op_if.op_code, 0);
        chk("rst_col", column_num, 0);     chk("rst_blk", mem_block_num, 0);
        chk("rst_use_s1", use_s1, 0);      chk("rst_sx", start_x, 0);
        chk("rst_sy", start_y, 0);
        reset_i = 1'b1;

        // Pure diagonal from (5,5).
        fill(5'd0); dirm[0][0] = 5'd5;
        run_walk("diag", 5, 5, 1'b1, 0, 1, 1);
        chk("diag_ops_literal", obs_q.size(), 5);
        nd = 0;
        foreach (obs_q[i]) if (obs_q[i] != 0) nd++;
        chk("diag_all_m", nd, 0);
        chk("diag_sx_literal", start_x, 0);

        // Short deletion: length-3 E run at y=20.
        fill(5'd0);
        dirm[20][26] = 5'd9; dirm[20][25] = 5'd9; dirm[20][24] = 5'd1;
        run_walk("del", 30, 24, 1'b0, 0, 1, 0);
        chk("del_ops_literal", obs_q.size(), 27);
        chk("del_op4", obs_q.size() > 6 ? obs_q[4] : -1, 1);
        chk("del_op6", obs_q.size() > 6 ? obs_q[6] : -1, 1);
        chk("del_op7", obs_q.size() > 7 ? obs_q[7] : -1, 0);
        chk("del_sx_literal", start_x, 3);
        ref_q = obs_q;

        // Same walk under alternating backpressure.
        run_walk("bp", 30, 24, 1'b0, 1, 0, 0);
        chk("bp_len", obs_q.size(), ref_q.size());
        diffs = 0;
        foreach (obs_q[i]) if (i >= ref_q.size() || obs_q[i] != ref_q[i]) diffs++;
        chk("bp_seq_diffs", diffs, 0);

        // Long insertion: Fhat run of 40 from (10,60).
        fill(5'd0);
        for (int y = 22; y <= 60; y++) dirm[y][10] = 5'd20;
        dirm[21][10] = 5'd4;
        run_walk("ins", 10, 60, 1'b1, 0, 1, 0);
        ni = 0;
        foreach (obs_q[i]) if (obs_q[i] == 2) ni++;
        chk("ins_i_literal", ni, 40);
        chk("ins_ops_literal", obs_q.size(), 50);
        chk("ins_sy_literal", start_y, 10);
        chk("ins_blocks_seen", blk_seen, 15);

        // Immediate stop at (7,9).
        dirm[9][7] = 5'd5;
        run_walk("stop", 7, 9, 1'b0, 0, 1, 0);
        chk("stop_ops_literal", obs_q.size(), 0);
        chk("stop_sx_literal", start_x, 7);
        chk("stop_sy_literal", start_y, 9);

        // Reset during the third step, then a normal walk.
        dirm[9][7] = 5'd0;
        model_walk(10, 60, n, nd, ni);
        ready_mode = 0;
        @(posedge clk); #1;
        tb_x = 8'd10; tb_y = 8'd60; bank_sel = 1'b1; start = 1'b1; tracking = 1;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (obs_q.size() < 2 && n < 200) begin @(posedge clk); #1; n++; end
        chk("mid_reached_step3", obs_q.size() >= 2, 1);
        reset_i = 1'b0; tracking = 0;
        #1;
        chk("mid_busy", busy, 0);            chk("mid_done", done, 0);
        chk("mid_valid", op_if.op_valid, 0); chk("mid_code", op_if.op_code, 0);
        chk("mid_col", column_num, 0);       chk("mid_blk", mem_block_num, 0);
        chk("mid_use_s1", use_s1, 0);        chk("mid_sx", start_x, 0);
        chk("mid_sy", start_y, 0);
        @(posedge clk); #1; reset_i = 1'b1;
        got = 0;
        repeat (12) begin @(posedge clk); #1; if (done || busy) got = 1; end
        chk("mid_no_done", got, 0);
        dirm[9][7] = 5'd5;
        run_walk("after_rst", 7, 9, 1'b1, 0, 1, 0);

        // Random matrices and random backpressure.
        for (int t = 0; t < 8; t++) begin
            for (int y = 0; y < 64; y++)
                for (int x = 0; x < 64; x++) dirm[y][x] = rand_code();
            run_walk($sformatf("rnd%0d", t), int'($urandom_range(1, 63)),
                     int'($urandom_range(1, 63)), 1'($urandom_range(0, 1)),
                     (t < 2) ? 0 : 2, t < 2, t == 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
